normalize_shifter: RTL and testbench
====================================

NORMALIZE_SHIFTER -- requirements
Module: normalize_shifter

Interface
REQ-001 SHALL have parameter N, default 32: data width; power of two, >= 2.
REQ-002 SHALL have parameter B, default $clog2(N): shift-amount width and number of iterative stages.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start_i, input, 1: request; accepted on an edge where start_i=1 and ready_o=1.
REQ-006 SHALL have port number_i, input, N: operand, captured on accept.
REQ-007 SHALL have port operation_i, input, 2: mode, captured on accept. 01 = LEFT (count leading zeros); 10 = RIGHT (count trailing zeros); 11 = ARIGHT (count redundant sign bits); 00 = pass-through.
REQ-008 SHALL have port ack_i, input, 1: consumer accepts the result.
REQ-009 SHALL have port ready_o, output, 1: idle, can accept a request.
REQ-010 SHALL have port valid_o, output, 1: result valid.
REQ-011 SHALL have port number_o, output, N: normalized operand.
REQ-012 SHALL have port shift_amount_o, output, B: shift applied.
REQ-013 SHALL have port zero_o, output, 1: captured operand was all zeros.

Function
REQ-014 SHALL implement FSM states IDLE, CALC and DONE. IDLE->CALC on accept. CALC->DONE after B stage cycles. DONE->IDLE on an edge with ack_i=1.
REQ-015 ready_o SHALL be 1 only in IDLE; valid_o SHALL be 1 only in DONE.
REQ-016 CALC SHALL evaluate one stage per cycle, with k = 2^(B-1) down to 1. Per stage:
- LEFT: if the top k bits are 0, shift left logical by k and set the amount bit.
- RIGHT: if the bottom k bits are 0, shift right logical by k and set the amount bit.
- ARIGHT: if the top k+1 bits are all equal, shift left by k and set the amount bit.
REQ-017 Latency SHALL be fixed: valid_o rises exactly B cycles after the accept edge (5 for N=32), independent of data and mode.
REQ-018 Pass-through mode SHALL also take B cycles, with number_o = operand and shift_amount_o = 0.
REQ-019 An all-zero operand SHALL give zero_o=1, shift_amount_o = N-1 and number_o = 0 in LEFT, RIGHT and ARIGHT modes. zero_o SHALL be 0 in pass-through mode.
REQ-020 An all-ones operand in ARIGHT mode SHALL give shift_amount_o = N-1, number_o = MSB-only, zero_o=0.
REQ-021 number_o, shift_amount_o and zero_o SHALL hold stable for the whole time valid_o=1, until ack.
REQ-022 start_i SHALL be ignored in CALC and DONE. It is not queued.
REQ-023 Changes on number_i and operation_i after the accept edge SHALL NOT affect the result.
REQ-024 start_i in the same cycle as an ack SHALL be ignored; a new request is accepted no earlier than the following cycle, in IDLE.
REQ-025 ack_i outside DONE SHALL have no effect.

Reset
REQ-026 On an edge with rst_i=1, from any state including mid-CALC, the block SHALL enter IDLE, abandoning any in-flight operation with no valid_o pulse.
REQ-027 Reset values SHALL be: ready_o=1, valid_o=0, number_o=0, shift_amount_o=0, zero_o=0.

Structure
REQ-028 The mode encodings (LEFT=01, RIGHT=10, ARIGHT=11) and the FSM state encodings SHALL live in the shared ALU package; barrelShifter uses the same mode encodings.
REQ-029 The per-stage compare-and-shift SHALL be one combinational sub-module, normalize_stage (inputs: data, mode, stage index; outputs: shifted data, hit).
REQ-030 The top level SHALL hold the FSM, a B-bit stage counter, the data register and the amount register.

Verification
REQ-031 LEFT mode, 0x00000001 -> after 5 cycles valid_o=1, number_o=0x80000000, shift_amount_o=31, zero_o=0.
REQ-032 RIGHT mode, 0x00000F00 -> number_o=0x0000000F, shift_amount_o=8. ARIGHT mode, 0xFFFF8000 -> number_o=0x80000000, shift_amount_o=16.
REQ-033 ARIGHT mode, 0x00000001 -> number_o=0x40000000, shift_amount_o=30. LEFT mode, 0x00000000 -> zero_o=1, shift_amount_o=31, number_o=0.
REQ-034 Back-pressure: hold ack_i=0 for 10 cycles and toggle start_i and number_i meanwhile -> outputs stable and valid_o held. Then ack_i=1 with start_i=1 in the same cycle -> IDLE next cycle, request not accepted.
REQ-035 Assert rst_i in the 3rd CALC cycle -> next cycle ready_o=1, valid_o=0, all outputs 0. A fresh request afterwards completes with the correct result.
REQ-036 Random 10k operands in all modes, checked against a reference model -> shifting number_o back by shift_amount_o (LEFT/ARIGHT: right shift; RIGHT: left shift) reproduces the operand.

Source files
------------

// File: rtl/normalize_shifter_pkg.sv
// rtl/normalize_shifter_pkg.sv - shared mode and FSM state encodings for the normalize shifter
package normalize_shifter_pkg;

    // Mode encodings are shared with the barrel shifter.
    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_RIGHT  = 2'b10,
        MODE_ARIGHT = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } norm_state_e;

endpackage

// File: rtl/normalize_shifter_if.sv
// rtl/normalize_shifter_if.sv - request/result handshake bundle for the normalize shifter
interface normalize_shifter_if #(
    parameter int N = 32,
    parameter int B = $clog2(N)
);
    logic         start_i;
    logic [N-1:0] number_i;
    logic [1:0]   operation_i;
    logic         ack_i;
    logic         ready_o;
    logic         valid_o;
    logic [N-1:0] number_o;
    logic [B-1:0] shift_amount_o;
    logic         zero_o;

    modport master (
        output start_i, number_i, operation_i, ack_i,
        input  ready_o, valid_o, number_o, shift_amount_o, zero_o
    );

    modport slave (
        input  start_i, number_i, operation_i, ack_i,
        output ready_o, valid_o, number_o, shift_amount_o, zero_o
    );
endinterface

// File: rtl/normalize_stage.sv
// rtl/normalize_stage.sv - one combinational compare-and-shift stage of width 2^stage
module normalize_stage
    import normalize_shifter_pkg::*;
#(
    parameter int N = 32,
    parameter int B = $clog2(N)
) (
    input  logic [N-1:0] data,
    input  shift_mode_e  mode,
    input  logic [B-1:0] stage,
    output logic [N-1:0] shifted,
    output logic         hit
);
    logic [B:0]   k;
    logic [N-1:0] ones;
    logic [N-1:0] top_k;
    logic [N-1:0] top_k1;
    logic [N-1:0] bot_k;

    assign k      = (B+1)'(1) << stage;
    assign ones   = '1;
    assign top_k  = ~(ones >> k);
    // k+1 top bits: the sign bit plus k redundant copies of it
    assign top_k1 = ~(ones >> (k + 1'b1));
    assign bot_k  = ~(ones << k);

    always_comb begin
        shifted = data;
        hit     = 1'b0;
        case (mode)
            MODE_LEFT: begin
                hit = ((data & top_k) == '0);
                if (hit) shifted = data << k;
            end
            MODE_RIGHT: begin
                hit = ((data & bot_k) == '0);
                if (hit) shifted = data >> k;
            end
            MODE_ARIGHT: begin
                hit = ((data & top_k1) == '0) || ((data & top_k1) == top_k1);
                if (hit) shifted = data << k;
            end
            default: begin
                hit     = 1'b0;
                shifted = data;
            end
        endcase
    end
endmodule

// File: rtl/normalize_shifter.sv
// rtl/normalize_shifter.sv - iterative normalizer: one binary-search stage per cycle, fixed B-cycle latency
module normalize_shifter
    import normalize_shifter_pkg::*;
#(
    parameter int N = 32,
    parameter int B = $clog2(N)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    normalize_shifter_if.slave bus
);
    norm_state_e  state_r;
    shift_mode_e  mode_r;
    logic [N-1:0] data_r;
    logic [B-1:0] amt_r;
    logic [B-1:0] cnt_r;
    logic         zero_r;

    logic [N-1:0] stage_data;
    logic         stage_hit;
    logic [B-1:0] stage_idx;
    logic [B-1:0] amt_next;

    // Largest stride first, so the counter maps to exponent B-1 down to 0.
    assign stage_idx = B'(B - 1) - cnt_r;
    assign amt_next  = amt_r | (B'(stage_hit) << stage_idx);

    normalize_stage #(
        .N (N),
        .B (B)
    ) u_stage (
        .data    (data_r),
        .mode    (mode_r),
        .stage   (stage_idx),
        .shifted (stage_data),
        .hit     (stage_hit)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r            <= ST_IDLE;
            mode_r             <= MODE_PASS;
            data_r             <= '0;
            amt_r              <= '0;
            cnt_r              <= '0;
            zero_r             <= 1'b0;
            bus.ready_o        <= 1'b1;
            bus.valid_o        <= 1'b0;
            bus.number_o       <= '0;
            bus.shift_amount_o <= '0;
            bus.zero_o         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        state_r     <= ST_CALC;
                        mode_r      <= shift_mode_e'(bus.operation_i);
                        data_r      <= bus.number_i;
                        amt_r       <= '0;
                        cnt_r       <= '0;
                        zero_r      <= (bus.number_i == '0) && (bus.operation_i != MODE_PASS);
                        bus.ready_o <= 1'b0;
                    end
                end
                ST_CALC: begin
                    data_r <= stage_data;
                    amt_r  <= amt_next;
                    cnt_r  <= cnt_r + 1'b1;
                    if (cnt_r == B'(B - 1)) begin
                        state_r            <= ST_DONE;
                        bus.valid_o        <= 1'b1;
                        bus.number_o       <= stage_data;
                        bus.shift_amount_o <= amt_next;
                        bus.zero_o         <= zero_r;
                    end
                end
                ST_DONE: begin
                    if (bus.ack_i) begin
                        state_r     <= ST_IDLE;
                        bus.valid_o <= 1'b0;
                        bus.ready_o <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    bus.valid_o <= 1'b0;
                    bus.ready_o <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_normalize_shifter.sv
// tb/tb_normalize_shifter.sv - directed self-checking bench for normalize_shifter
module tb_normalize_shifter;
    localparam int N = 32;
    localparam int B = 5;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    normalize_shifter_if #(.N(N), .B(B)) bus ();

    normalize_shifter #(.N(N), .B(B)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request, holds start_i high and scrambles inputs while busy, then acks.
    task automatic run_op(input logic [1:0] op, input logic [31:0] num,
                          output logic [31:0] res, output logic [4:0] amt, output logic z);
        int lat;
        chk("ready_before_req", 32'(bus.ready_o), 32'd1);
        bus.start_i     = 1'b1;
        bus.number_i    = num;
        bus.operation_i = op;
        step();
        bus.number_i    = $urandom;
        bus.operation_i = 2'($urandom);
        lat = 0;
        while (!bus.valid_o && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'd5);
        res = bus.number_o;
        amt = bus.shift_amount_o;
        z   = bus.zero_o;
        bus.ack_i = 1'b1;
        step();
        bus.ack_i   = 1'b0;
        bus.start_i = 1'b0;
        chk("ready_after_ack", 32'(bus.ready_o), 32'd1);
        chk("valid_after_ack", 32'(bus.valid_o), 32'd0);
    endtask

    task automatic check_op(input string tag, input logic [1:0] op, input logic [31:0] num,
                            input logic [31:0] en, input logic [4:0] ea, input logic ez);
        logic [31:0] res;
        logic [4:0]  amt;
        logic        z;
        run_op(op, num, res, amt, z);
        chk({tag, "_number"}, res, en);
        chk({tag, "_amount"}, 32'(amt), 32'(ea));
        chk({tag, "_zero"}, 32'(z), 32'(ez));
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] num;
        logic [31:0] held_num;
        logic [4:0]  amt;
        logic [4:0]  held_amt;
        logic [1:0]  op;
        logic        z;
        int          lat;

        errors          = 0;
        checks          = 0;
        rst             = 1'b1;
        bus.start_i     = 1'b0;
        bus.number_i    = '0;
        bus.operation_i = 2'b00;
        bus.ack_i       = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready",  32'(bus.ready_o),        32'd1);
        chk("rst_valid",  32'(bus.valid_o),        32'd0);
        chk("rst_number", bus.number_o,            32'd0);
        chk("rst_amount", 32'(bus.shift_amount_o), 32'd0);
        chk("rst_zero",   32'(bus.zero_o),         32'd0);

        check_op("left_1",        2'b01, 32'h0000_0001, 32'h8000_0000, 5'd31, 1'b0);
        check_op("right_f00",     2'b10, 32'h0000_0F00, 32'h0000_000F, 5'd8,  1'b0);
        check_op("aright_ffff8",  2'b11, 32'hFFFF_8000, 32'h8000_0000, 5'd16, 1'b0);
        check_op("aright_1",      2'b11, 32'h0000_0001, 32'h4000_0000, 5'd30, 1'b0);
        check_op("left_0",        2'b01, 32'h0000_0000, 32'h0000_0000, 5'd31, 1'b1);
        check_op("right_0",       2'b10, 32'h0000_0000, 32'h0000_0000, 5'd31, 1'b1);
        check_op("aright_0",      2'b11, 32'h0000_0000, 32'h0000_0000, 5'd31, 1'b1);
        check_op("aright_ones",   2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 5'd31, 1'b0);
        check_op("pass_val",      2'b00, 32'h1234_5678, 32'h1234_5678, 5'd0,  1'b0);
        check_op("pass_0",        2'b00, 32'h0000_0000, 32'h0000_0000, 5'd0,  1'b0);
        check_op("left_msb",      2'b01, 32'h8000_0000, 32'h8000_0000, 5'd0,  1'b0);
        check_op("right_msb",     2'b10, 32'h8000_0000, 32'h0000_0001, 5'd31, 1'b0);
        check_op("aright_4",      2'b11, 32'h4000_0000, 32'h4000_0000, 5'd0,  1'b0);
        check_op("left_f0",       2'b01, 32'h00F0_0000, 32'hF000_0000, 5'd8,  1'b0);

        // Back-pressure: result held while ack_i stays low and inputs churn.
        bus.start_i     = 1'b1;
        bus.number_i    = 32'h0000_0001;
        bus.operation_i = 2'b01;
        step();
        bus.start_i = 1'b0;
        lat = 0;
        while (!bus.valid_o && lat < 20) begin
            step();
            lat++;
        end
        chk("bp_latency", 32'(lat), 32'd5);
        held_num = bus.number_o;
        held_amt = bus.shift_amount_o;
        chk("bp_number", held_num, 32'h8000_0000);
        chk("bp_amount", 32'(held_amt), 32'd31);
        for (int i = 0; i < 10; i++) begin
            bus.start_i  = ~bus.start_i;
            bus.number_i = $urandom;
            step();
            chk("bp_valid_held",  32'(bus.valid_o),        32'd1);
            chk("bp_number_held", bus.number_o,            32'h8000_0000);
            chk("bp_amount_held", 32'(bus.shift_amount_o), 32'd31);
            chk("bp_zero_held",   32'(bus.zero_o),         32'd0);
        end
        bus.ack_i    = 1'b1;
        bus.start_i  = 1'b1;
        bus.number_i = 32'h0000_0F00;
        step();
        bus.ack_i   = 1'b0;
        bus.start_i = 1'b0;
        chk("ack_start_ready", 32'(bus.ready_o), 32'd1);
        chk("ack_start_valid", 32'(bus.valid_o), 32'd0);
        step();
        chk("ack_start_not_taken", 32'(bus.ready_o), 32'd1);

        // Reset in the third CALC cycle abandons the operation.
        bus.start_i     = 1'b1;
        bus.number_i    = 32'h0000_0001;
        bus.operation_i = 2'b01;
        step();
        bus.start_i = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_ready",  32'(bus.ready_o),        32'd1);
        chk("mid_rst_valid",  32'(bus.valid_o),        32'd0);
        chk("mid_rst_number", bus.number_o,            32'd0);
        chk("mid_rst_amount", 32'(bus.shift_amount_o), 32'd0);
        chk("mid_rst_zero",   32'(bus.zero_o),         32'd0);
        for (int i = 0; i < 6; i++) step();
        chk("mid_rst_no_valid", 32'(bus.valid_o), 32'd0);
        check_op("post_rst_right", 2'b10, 32'h0000_0F00, 32'h0000_000F, 5'd8, 1'b0);

        // Random nonzero operands: undoing the shift must reproduce the operand.
        for (int i = 0; i < 200; i++) begin
            op  = 2'($urandom_range(1, 3));
            num = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) num = ~num;
            if (num == 32'd0) num = 32'd1;
            run_op(op, num, res, amt, z);
            chk("rnd_zero", 32'(z), 32'd0);
            case (op)
                2'b01: begin
                    chk("rnd_left_back", res >> amt, num);
                    chk("rnd_left_norm", 32'(res[31]), 32'd1);
                end
                2'b10: begin
                    chk("rnd_right_back", res << amt, num);
                    chk("rnd_right_norm", 32'(res[0]), 32'd1);
                end
                default: begin
                    chk("rnd_aright_back", 32'($signed(res) >>> amt), num);
                    chk("rnd_aright_norm", 32'(res[31] ^ res[30]), 32'd1);
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
